// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, step encodings and
// parameter defaults.
package control_sequencer_pkg;

  localparam int OPC_W_DEFAULT    = 5;
  localparam int WAIT_MAX_DEFAULT = 16;

  localparam logic [OPC_W_DEFAULT-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W_DEFAULT-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W_DEFAULT-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W_DEFAULT-1:0] OP_ADDI = 5'b00011;
  localparam logic [OPC_W_DEFAULT-1:0] OP_HALT = 5'b11010;

  // Enum values double as the externally visible step index.
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd15
  } state_e;

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts cycles a memory step spends waiting for mem_ready and flags a
// timeout, producing a one-cycle registered mem_err pulse.
module mem_wait_timer
  import control_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic busy,
  input  logic mem_ready,
  output logic expire,
  output logic mem_err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             mem_err_q, mem_err_d;

  // start arrives the cycle before a memory step begins, so the step opens at zero.
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (start) begin
      count_d = '0;
    end else if (busy && !mem_ready) begin
      count_d = count_q + 1'b1;
      if (count_q == LAST) begin
        expire = 1'b1;
      end
    end
    mem_err_d = expire;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control sequencer: T0-T7 fetch/execute steps for ld, ldi, st,
// addi and halt, with strobes decoded from registered state only.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int OPC_W    = OPC_W_DEFAULT,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  input  logic            stall,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Rout,
  output logic            BAout,
  output logic            Csignout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Rin,
  output logic            Gra,
  output logic            Grb,
  output logic            IncPC,
  output logic            ADD,
  output logic            Read,
  output logic            Write,
  output logic [3:0]      step,
  output logic            run,
  output logic            mem_err,
  output logic            illegal_op
);

  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(OP_LD);
  localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(OP_LDI);
  localparam logic [OPC_W-1:0] OPC_ST   = OPC_W'(OP_ST);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(OP_ADDI);
  localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(OP_HALT);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             run_q, run_d;
  logic             first_q, first_d;
  logic             mem_start, mem_busy, expire;
  logic             is_ld, is_ldi, is_st, is_addi, op_legal;
  logic [OPC_W-1:0] ir_opc;
  logic             unused_ir_bits;

  assign ir_opc         = ir[IR_W-1 -: OPC_W];
  assign unused_ir_bits = ^ir[IR_W-OPC_W-1:0];

  assign is_ld    = (opc_q == OPC_LD);
  assign is_ldi   = (opc_q == OPC_LDI);
  assign is_st    = (opc_q == OPC_ST);
  assign is_addi  = (opc_q == OPC_ADDI);
  assign op_legal = is_ld | is_ldi | is_st | is_addi;

  function automatic logic is_mem_step(input state_e s, input logic [OPC_W-1:0] op);
    return (s == ST_T1) || (s == ST_T6 && op == OPC_LD) || (s == ST_T7 && op == OPC_ST);
  endfunction

  // run_q low with state T0 marks the idle cycle right after reset; HALT also keeps it low.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    run_d   = run_q;
    if (!run_q) begin
      if (state_q == ST_T0) begin
        run_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_T0: if (!stall) state_d = ST_T1;
        ST_T1: begin
          if (expire)         state_d = ST_HALT;
          else if (mem_ready) state_d = ST_T2;
        end
        ST_T2: begin
          opc_d   = ir_opc;
          state_d = (ir_opc == OPC_HALT) ? ST_HALT : ST_T3;
        end
        ST_T3: state_d = op_legal ? ST_T4 : ST_T0;
        ST_T4: state_d = ST_T5;
        ST_T5: state_d = (is_ld || is_st) ? ST_T6 : ST_T0;
        ST_T6: begin
          if (is_ld) begin
            if (expire)         state_d = ST_HALT;
            else if (mem_ready) state_d = ST_T7;
          end else begin
            state_d = ST_T7;
          end
        end
        ST_T7: begin
          if (is_st) begin
            if (expire)         state_d = ST_HALT;
            else if (mem_ready) state_d = ST_T0;
          end else begin
            state_d = ST_T0;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_T0;
      endcase
      run_d = (state_d != ST_HALT);
    end
  end

  assign mem_busy  = run_q && is_mem_step(state_q, opc_q);
  assign mem_start = run_q && is_mem_step(state_d, opc_q) && (state_d != state_q);
  assign first_d   = mem_start;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_T0;
      opc_q   <= '0;
      run_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      run_q   <= run_d;
      first_q <= first_d;
    end
  end

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_mem_wait_timer (
    .clock     (clock),
    .clear     (clear),
    .start     (mem_start),
    .busy      (mem_busy),
    .mem_ready (mem_ready),
    .expire    (expire),
    .mem_err   (mem_err)
  );

  // Stall is the one input allowed to mask strobes, and only in T0.
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Csignout   = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Rin        = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    IncPC      = 1'b0;
    ADD        = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    illegal_op = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_T0: begin
          if (!stall) begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
          end
        end
        ST_T1: begin
          Zlowout = 1'b1;
          PCin    = first_q;
          Read    = 1'b1;
          MDRin   = 1'b1;
        end
        ST_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        ST_T3: begin
          if (op_legal) begin
            Grb   = 1'b1;
            Yin   = 1'b1;
            BAout = !is_addi;
            Rout  = is_addi;
          end else begin
            illegal_op = 1'b1;
          end
        end
        ST_T4: begin
          Csignout = 1'b1;
          ADD      = 1'b1;
          Zlowin   = 1'b1;
        end
        ST_T5: begin
          Zlowout = 1'b1;
          if (is_ld || is_st) begin
            MARin = 1'b1;
          end else begin
            Gra = 1'b1;
            Rin = 1'b1;
          end
        end
        ST_T6: begin
          MDRin = 1'b1;
          if (is_ld) begin
            Read = 1'b1;
          end else begin
            Gra  = 1'b1;
            Rout = 1'b1;
          end
        end
        ST_T7: begin
          MDRout = 1'b1;
          if (is_st) begin
            Write = 1'b1;
          end else begin
            Gra = 1'b1;
            Rin = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign step = state_q;
  assign run  = run_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: fixed instruction scenarios with
// hand-written per-cycle expected steps and strobe sets.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        mem_ready = 1'b1;
  logic        stall = 1'b0;
  logic PCout, Zlowout, MDRout, Rout, BAout, Csignout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
  logic Gra, Grb, IncPC, ADD, Read, Write;
  logic [3:0] step;
  logic run, mem_err, illegal_op;
  logic [18:0] strobes;

  int checks = 0;
  int errors = 0;

  localparam logic [18:0] S_PCOUT   = 19'd1 << 18;
  localparam logic [18:0] S_ZLOWOUT = 19'd1 << 17;
  localparam logic [18:0] S_MDROUT  = 19'd1 << 16;
  localparam logic [18:0] S_ROUT    = 19'd1 << 15;
  localparam logic [18:0] S_BAOUT   = 19'd1 << 14;
  localparam logic [18:0] S_CSIGN   = 19'd1 << 13;
  localparam logic [18:0] S_PCIN    = 19'd1 << 12;
  localparam logic [18:0] S_MARIN   = 19'd1 << 11;
  localparam logic [18:0] S_MDRIN   = 19'd1 << 10;
  localparam logic [18:0] S_IRIN    = 19'd1 << 9;
  localparam logic [18:0] S_YIN     = 19'd1 << 8;
  localparam logic [18:0] S_ZLOWIN  = 19'd1 << 7;
  localparam logic [18:0] S_RIN     = 19'd1 << 6;
  localparam logic [18:0] S_GRA     = 19'd1 << 5;
  localparam logic [18:0] S_GRB     = 19'd1 << 4;
  localparam logic [18:0] S_INCPC   = 19'd1 << 3;
  localparam logic [18:0] S_ADD     = 19'd1 << 2;
  localparam logic [18:0] S_READ    = 19'd1 << 1;
  localparam logic [18:0] S_WRITE   = 19'd1 << 0;

  localparam logic [18:0] X_T0    = S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN;
  localparam logic [18:0] X_T1    = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [18:0] X_T1W   = S_ZLOWOUT | S_READ | S_MDRIN;
  localparam logic [18:0] X_T2    = S_MDROUT | S_IRIN;
  localparam logic [18:0] X_T3M   = S_GRB | S_BAOUT | S_YIN;
  localparam logic [18:0] X_T3A   = S_GRB | S_ROUT | S_YIN;
  localparam logic [18:0] X_T4    = S_CSIGN | S_ADD | S_ZLOWIN;
  localparam logic [18:0] X_T5ADR = S_ZLOWOUT | S_MARIN;
  localparam logic [18:0] X_T5WB  = S_ZLOWOUT | S_GRA | S_RIN;
  localparam logic [18:0] X_T6LD  = S_READ | S_MDRIN;
  localparam logic [18:0] X_T7LD  = S_MDROUT | S_GRA | S_RIN;
  localparam logic [18:0] X_T6ST  = S_GRA | S_ROUT | S_MDRIN;
  localparam logic [18:0] X_T7ST  = S_MDROUT | S_WRITE;

  assign strobes = {PCout, Zlowout, MDRout, Rout, BAout, Csignout, PCin, MARin, MDRin,
                    IRin, Yin, Zlowin, Rin, Gra, Grb, IncPC, ADD, Read, Write};

  control_sequencer #(
    .IR_W     (32),
    .OPC_W    (5),
    .WAIT_MAX (8)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .PCout      (PCout),
    .Zlowout    (Zlowout),
    .MDRout     (MDRout),
    .Rout       (Rout),
    .BAout      (BAout),
    .Csignout   (Csignout),
    .PCin       (PCin),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zlowin     (Zlowin),
    .Rin        (Rin),
    .Gra        (Gra),
    .Grb        (Grb),
    .IncPC      (IncPC),
    .ADD        (ADD),
    .Read       (Read),
    .Write      (Write),
    .step       (step),
    .run        (run),
    .mem_err    (mem_err),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    clear = 1'b0;
    mem_ready = 1'b1;
    stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    tick();
    tick();
    checks++;
    if (step !== 4'd0) begin errors++; $display("FAIL reset_step got=%0d want=0", step); end
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL reset_run got=%b want=0", run); end
    checks++;
    if (strobes !== 19'h0) begin errors++; $display("FAIL reset_strobes got=%05h want=00000", strobes); end
    checks++;
    if (mem_err !== 1'b0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got mem_err=%b illegal_op=%b want 0 0", mem_err, illegal_op);
    end
    clear = 1'b1;
  endtask

  task automatic test_ldi();
    logic [3:0]  es [7];
    logic [18:0] ex [7];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    ex = '{X_T0, X_T1, X_T2, X_T3M, X_T4, X_T5WB, X_T0};
    ir = 32'h08800000;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i] || run !== 1'b1) begin
        errors++;
        $display("FAIL ldi cyc%0d got step=%0d strobes=%05h run=%b want step=%0d strobes=%05h run=1",
                 i, step, strobes, run, es[i], ex[i]);
      end
    end
  endtask

  task automatic test_ld_wait();
    logic [3:0]  es [11];
    logic [18:0] ex [11];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
    ex = '{X_T1, X_T2, X_T3M, X_T4, X_T5ADR, X_T6LD, X_T6LD, X_T6LD, X_T6LD, X_T7LD, X_T0};
    ir = 32'h00800000;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i]) begin
        errors++;
        $display("FAIL ld_wait cyc%0d got step=%0d strobes=%05h want step=%0d strobes=%05h",
                 i, step, strobes, es[i], ex[i]);
      end
      mem_ready = !(i >= 5 && i <= 7);
    end
  endtask

  task automatic test_st_wait();
    logic [3:0]  es [11];
    logic [18:0] ex [11];
    es = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 4'd0};
    ex = '{X_T1, X_T1W, X_T2, X_T3M, X_T4, X_T5ADR, X_T6ST, X_T7ST, X_T7ST, X_T7ST, X_T0};
    ir = 32'h10000000;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i]) begin
        errors++;
        $display("FAIL st_wait cyc%0d got step=%0d strobes=%05h want step=%0d strobes=%05h",
                 i, step, strobes, es[i], ex[i]);
      end
      mem_ready = !(i == 0 || i == 7 || i == 8);
    end
  endtask

  task automatic test_mem_timeout();
    int pulses = 0;
    logic [3:0]  exp_step;
    logic [18:0] exp_strb;
    ir = 32'h00800000;
    for (int i = 0; i < 14; i++) begin
      tick();
      case (i)
        0:       begin exp_step = 4'd1;  exp_strb = X_T1;    end
        1:       begin exp_step = 4'd2;  exp_strb = X_T2;    end
        2:       begin exp_step = 4'd3;  exp_strb = X_T3M;   end
        3:       begin exp_step = 4'd4;  exp_strb = X_T4;    end
        4:       begin exp_step = 4'd5;  exp_strb = X_T5ADR; end
        13:      begin exp_step = 4'd15; exp_strb = 19'h0;   end
        default: begin exp_step = 4'd6;  exp_strb = X_T6LD;  end
      endcase
      checks++;
      if (step !== exp_step || strobes !== exp_strb || mem_err !== (i == 13) || run !== (i != 13)) begin
        errors++;
        $display("FAIL timeout cyc%0d got step=%0d strobes=%05h mem_err=%b run=%b want step=%0d strobes=%05h mem_err=%b run=%b",
                 i, step, strobes, mem_err, run, exp_step, exp_strb, (i == 13), (i != 13));
      end
      if (mem_err === 1'b1) pulses++;
      if (i == 1) mem_ready = 1'b0;
    end
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (step !== 4'd15 || run !== 1'b0 || strobes !== 19'h0 || mem_err !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold cyc%0d got step=%0d run=%b strobes=%05h mem_err=%b want 15 0 00000 0",
                 i, step, run, strobes, mem_err);
      end
      if (mem_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL mem_err_pulses got=%0d want=1", pulses); end
    mem_ready = 1'b1;
  endtask

  task automatic test_halt_op();
    logic [3:0]  es [8];
    logic [18:0] ex [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    ex = '{X_T0, X_T1, X_T2, 19'h0, 19'h0, 19'h0, 19'h0, 19'h0};
    apply_reset();
    ir = 32'hD0000000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i] || run !== (i < 3)) begin
        errors++;
        $display("FAIL halt_op cyc%0d got step=%0d strobes=%05h run=%b want step=%0d strobes=%05h run=%b",
                 i, step, strobes, run, es[i], ex[i], (i < 3));
      end
    end
  endtask

  task automatic test_illegal_op();
    int pulses = 0;
    logic [3:0]  es [6];
    logic [18:0] ex [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    ex = '{X_T0, X_T1, X_T2, 19'h0, X_T0, X_T1};
    apply_reset();
    ir = 32'hF8000000;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i] || illegal_op !== (i == 3)) begin
        errors++;
        $display("FAIL illegal cyc%0d got step=%0d strobes=%05h illegal_op=%b want step=%0d strobes=%05h illegal_op=%b",
                 i, step, strobes, illegal_op, es[i], ex[i], (i == 3));
      end
      if (illegal_op === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL illegal_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_reset_stall();
    logic [3:0]  es [5];
    logic [18:0] ex [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ex = '{X_T0, X_T1, X_T2, X_T3A, X_T4};
    apply_reset();
    ir = 32'h18000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (step !== es[i] || strobes !== ex[i]) begin
        errors++;
        $display("FAIL addi cyc%0d got step=%0d strobes=%05h want step=%0d strobes=%05h",
                 i, step, strobes, es[i], ex[i]);
      end
    end
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (strobes !== 19'h0 || step !== 4'd0 || run !== 1'b0) begin
      errors++;
      $display("FAIL async_clear got strobes=%05h step=%0d run=%b want 00000 0 0", strobes, step, run);
    end
    stall = 1'b1;
    tick();
    clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (step !== 4'd0 || strobes !== 19'h0 || run !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc%0d got step=%0d strobes=%05h run=%b want 0 00000 1", i, step, strobes, run);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (strobes !== X_T0) begin
      errors++; $display("FAIL unstall got strobes=%05h want %05h", strobes, X_T0);
    end
    tick();
    checks++;
    if (step !== 4'd1 || strobes !== X_T1) begin
      errors++; $display("FAIL resume_fetch got step=%0d strobes=%05h want 1 %05h", step, strobes, X_T1);
    end
  endtask

  initial begin
    $display("[TB] control_sequencer directed run");
    test_reset();
    test_ldi();
    test_ld_wait();
    test_st_wait();
    test_mem_timeout();
    test_halt_op();
    test_illegal_op();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter IR_W, default 32: instruction register width; minimum 32.
REQ-002 Parameter OPC_W, default 5: opcode field width, taken from ir[IR_W-1 -: OPC_W].
REQ-003 Parameter WAIT_MAX, default 16: maximum cycles spent waiting for mem_ready in any memory step; minimum 1.
REQ-004 One clock; reset is asynchronous and active-low. The ports are named clock and clear, as elsewhere in the codebase: clock is the single clock, clear is the asynchronous active-low reset.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- ir  in  IR_W  current IR contents from the datapath.
- mem_ready  in  1  memory has completed the current Read or Write.
- stall  in  1  holds the sequencer in T0.
- PCout, Zlowout, MDRout, Rout, BAout, Csignout  out  1 each  bus drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin  out  1 each  register load strobes.
- Gra, Grb, IncPC, ADD, Read, Write  out  1 each  select, ALU and memory strobes.
- step  out  4  current step index: 0-7 for T0-T7, 15 for HALT.
- run  out  1  high while not halted.
- mem_err  out  1  one-cycle memory-timeout pulse.
- illegal_op  out  1  one-cycle undefined-opcode pulse.

Function
REQ-006 Moore machine; every strobe decodes from the state register only, and each step lasts one clock unless stated otherwise.
REQ-007 T0: PCout, MARin, IncPC, Zlowin.
- If stall=1, the sequencer stays in T0 with all strobes at 0.
REQ-008 T1: Zlowout, PCin, Read, MDRin.
- PCin is asserted in the first cycle of T1 only.
- T1 holds until mem_ready=1.
REQ-009 T2: MDRout, IRin; the opcode is decoded from ir on the following edge.
REQ-010 ld (00000):
- T3: Grb, BAout, Yin.
- T4: Csignout, ADD, Zlowin.
- T5: Zlowout, MARin.
- T6: Read, MDRin; holds until mem_ready.
- T7: MDRout, Gra, Rin; then T0.
REQ-011 ldi (00001): T3 and T4 as ld; T5: Zlowout, Gra, Rin; then T0.
REQ-012 st (00010):
- T3 to T5 as ld.
- T6: Gra, Rout, MDRin.
- T7: MDRout, Write; holds until mem_ready; then T0.
REQ-013 addi (00011):
- T3: Grb, Rout, Yin.
- T4: Csignout, ADD, Zlowin.
- T5: Zlowout, Gra, Rin; then T0.
REQ-014 halt (11010): move to HALT; all strobes 0, run=0, step=15; HALT is left only through clear.
REQ-015 Any other opcode: illegal_op pulses for 1 cycle in T3, no strobes are asserted, next state T0.
REQ-016 Memory wait counter:
- Cleared on entry to each memory step.
- Increments each cycle with mem_ready=0.
- On reaching WAIT_MAX without mem_ready: mem_err pulses for 1 cycle, the sequencer enters HALT and Read/Write drop the same cycle.
REQ-017 mem_ready=1 on the first cycle of a memory step means the step lasts exactly one cycle; mem_ready outside memory steps is ignored.
REQ-018 Read and Write are never high together; at most one of PCout, Zlowout, MDRout, Rout, BAout, Csignout is high in any cycle.

Reset
REQ-019 While clear=0, regardless of clock:
- state=T0, step=0, run=0.
- all strobes, mem_err and illegal_op are 0.
- wait counter is 0.
REQ-020 run=1 from the first rising edge after clear deasserts.
- T0 strobes assert in that first cycle unless stall=1.
- Reset mid-instruction abandons the instruction without completing any pending strobe.

Structure
REQ-021 A shared package holds:
- the opcode constants (LD, LDI, ST, ADDI, HALT);
- the state enum T0-T7 and HALT, with step encodings;
- the defaults for OPC_W and WAIT_MAX.
REQ-022 One sub-module, mem_wait_timer, holds the WAIT_MAX counter, its start/ready/expire logic and the mem_err pulse; the rest is flat.

Verification (mem_ready=1 unless stated)
REQ-023 ldi, ir=32'h08800000:
- T3 Grb+BAout+Yin, T4 ADD+Zlowin, T5 Gra+Rin.
- Back in T0 6 cycles after leaving reset.
REQ-024 ld with mem_ready low for 3 cycles in T6: Read and MDRin high for 4 cycles, then T7 MDRout+Gra+Rin.
REQ-025 st with mem_ready low for 2 cycles in T7: Write high for 3 cycles, Read never high in T6/T7.
REQ-026 ld with mem_ready stuck at 0, WAIT_MAX=8:
- mem_err pulses once after 8 T6 wait cycles.
- Then run=0, step=15, and it stays in HALT for 20+ further cycles.
REQ-027 Opcode 11010: HALT reached after T2. Opcode 11111: illegal_op pulses once, next instruction fetched at T0.
REQ-028 Reset and stall:
- clear pulled low mid-T4 of addi: all strobes go 0 asynchronously.
- After release: T0 fetch resumes.
- stall=1 in T0 for 5 cycles: zero strobes, step=0 throughout.
